lbp_stream_engine: RTL and testbench
====================================

# lbp_stream_engine

Parametrised Local Binary Pattern engine for the image-processing datapath. It reads a 2^LOG_W × 2^LOG_H grayscale image from the synchronous gray memory and writes one 8-bit LBP code per interior pixel to the lbp memory. Compared with the fixed 128×128, 8-bit engine, it adds:
- configurable image size and pixel width;
- a programmable comparison threshold;
- an optional border-fill pass.

It reuses the two overlapping window columns, so only three pixels are fetched per step along a row.

## Interface
- LOG_W, default 7, log2 of image width W (W ≥ 4).
- LOG_H, default 7, log2 of image height H (H ≥ 4).
- DW, default 8, gray pixel width in bits.
- BORDER_ZERO, default 0. When 1, all border pixels are written with code 0x00 after the interior pass.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- gray_ready  input  1  image available. Sampled only in IDLE.
- gray_data  input  DW  pixel value. Valid the cycle after gray_req=1 with gray_addr.
- thr  input  DW  comparison threshold. Must be held stable while running.
- gray_req  output  1  read strobe.
- gray_addr  output  LOG_W+LOG_H  read address = row·W + col.
- lbp_valid  output  1  write strobe, one cycle per code.
- lbp_addr  output  LOG_W+LOG_H  write address.
- lbp_data  output  8  LBP code.
- finish  output  1  run complete. Sticky until reset.

## Operation
- Reset value of every output is 0. Window centre resets to (row 1, col 1), and the window buffer is cleared.
- The window buffer holds nine DW-bit registers, indexed 0..8 in raster order; index 4 is the centre.
- States and transitions:
  - IDLE: waits for gray_ready=1, then goes to FETCH9.
  - FETCH9: issues 9 addresses in raster order, (r−1,c−1) through (r+1,c+1), one per cycle, with gray_req=1. Data from the previous cycle's address is captured into the buffer each cycle.
  - FETCH3: issues 3 addresses for the new right column, (r−1,c+1), (r,c+1), (r+1,c+1). Before the first capture, the buffer shifts left (0←1, 1←2, 3←4, 4←5, 6←7, 7←8).
  - LAST: gray_req=0; captures the final datum.
  - CMP: registers 8 compare bits.
  - WR: drives lbp_valid=1, lbp_addr=r·W+c, and lbp_data.
  - After WR:
    - if c < W−2: c+1, go to FETCH3;
    - else if r < H−2: r+1, c=1, go to FETCH9;
    - else go to BORDER (if BORDER_ZERO=1) or DONE.
  - BORDER: one write per cycle with lbp_valid=1, lbp_data=0x00, covering every pixel with row∈{0,H−1} or col∈{0,W−1}, in ascending address order. That is 2W+2H−4 writes, then DONE.
  - DONE: finish=1, gray_req=0, lbp_valid=0. Stays until reset.
- Compare rule: bit k=1 iff neighbour ≥ centre + thr.
  - The sum is formed in DW+1 bits and is not saturated, so if centre+thr > 2^DW−1 the bit is 0.
  - Comparisons are unsigned.
- Bit order: bit0..bit7 = buffer indices 0,1,2,3,5,6,7,8.
- Boundary conditions:
  - gray_ready is ignored outside IDLE. Deassertion mid-run has no effect.
  - Reset mid-run aborts immediately and returns to IDLE/(1,1). A new run restarts from scratch.
  - No write is issued for the same address twice.
  - The last interior write is address (H−2)·W+(W−2).

## Timing
- Row-start pixel: 9 FETCH9 + LAST + CMP + WR = 12 cycles from first gray_req to the end of lbp_valid.
- Subsequent pixels in the row: 3 FETCH3 + LAST + CMP + WR = 6 cycles per code.
- Interior pass total: (H−2)·(12 + 6·(W−3)) cycles.
  - For the 128×128 default this is 96012 cycles.
- IDLE→FETCH9: gray_req rises the cycle after gray_ready is sampled high.
- Border pass: 2W+2H−4 consecutive lbp_valid cycles. finish rises the cycle after the last lbp_valid.
- gray_req is never high in the same cycle as lbp_valid.

## Test plan
- LOG_W=LOG_H=3, DW=8, constant image 0x40, thr=0:
  - 36 writes, all 0xFF, addresses 9..54 excluding border columns;
  - finish rises 252 cycles after the first gray_req (+1).
- Same image, thr=1: all 36 codes are 0x00.
- Horizontal ramp pixel=col·10, thr=0: every code is 0xD6 (right column and centre column ≥ centre).
- Centre 0xF0 with thr=0x20 (sum overflows 8 bits): code is 0x00 even with all neighbours 0xFF.
- BORDER_ZERO=1, 8×8:
  - 28 border writes of 0x00 in ascending address order (0..7, 8, 15, …, 56..63) follow the interior pass;
  - total lbp_valid count is 64.
- Reset asserted mid-row 3:
  - all outputs go to 0 immediately;
  - re-raising gray_ready restarts at (1,1) and produces correct codes;
  - finish only appears at the end of the full run.
- DW=10, LOG_W=4, LOG_H=3, random image: codes match the golden model bit-for-bit; gray_req count = 6·(9+3·13).

Source files
------------

// File: rtl/lbp_stream_engine.sv
// Local Binary Pattern engine: streams a 2^LOG_W x 2^LOG_H gray image through a
// 3x3 window and writes one 8-bit code per interior pixel, optionally zeroing the border.
module lbp_stream_engine #(
   parameter int LOG_W       = 7,
   parameter int LOG_H       = 7,
   parameter int DW          = 8,
   parameter bit BORDER_ZERO = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   gray_ready,
   input  logic [DW-1:0]          gray_data,
   input  logic [DW-1:0]          thr,
   output logic                   gray_req,
   output logic [LOG_W+LOG_H-1:0] gray_addr,
   output logic                   lbp_valid,
   output logic [LOG_W+LOG_H-1:0] lbp_addr,
   output logic [7:0]             lbp_data,
   output logic                   finish
);
   localparam int AW = LOG_W + LOG_H;
   localparam int W  = 1 << LOG_W;
   localparam int H  = 1 << LOG_H;

   typedef enum logic [2:0] {IDLE, FETCH9, FETCH3, LAST, CMP, WR, BORDER, DONE} state_t;

   state_t              state;
   logic [LOG_H-1:0]    row;
   logic [LOG_W-1:0]    col;
   logic [3:0]          idx;
   logic [8:0][DW-1:0]  win;

   // Sum kept one bit wider so an overflowing centre+thr makes every bit 0.
   logic [DW:0] limit;
   logic [7:0]  code;
   assign limit = {1'b0, win[4]} + {1'b0, thr};

   for (genvar k = 0; k < 8; k++) begin : g_cmp
      localparam int SRC = (k < 4) ? k : k + 1;
      assign code[k] = ({1'b0, win[SRC]} >= limit);
   end

   logic [3:0]       nj, cbase;
   logic [1:0]       roff, coff;
   logic [LOG_H-1:0] f9_row, f3_row, b_row;
   logic [LOG_W-1:0] f9_col, f3_col, b_col;
   logic [AW-1:0]    b_next;

   always_comb begin
      nj     = idx + 4'd1;
      roff   = (nj >= 4'd6) ? 2'd2 : (nj >= 4'd3) ? 2'd1 : 2'd0;
      cbase  = {1'b0, roff, 1'b0} + {2'b00, roff};
      coff   = 2'(nj - cbase);
      f9_row = row + LOG_H'(roff) - LOG_H'(1);
      f9_col = col + LOG_W'(coff) - LOG_W'(1);
      f3_row = row + LOG_H'(nj[1:0]) - LOG_H'(1);
      f3_col = col + LOG_W'(1);
      b_row  = lbp_addr[AW-1:LOG_W];
      b_col  = lbp_addr[LOG_W-1:0];
      // On an inner row the left border pixel jumps straight to the right one.
      b_next = (b_row != '0 && b_row != '1 && b_col == '0) ? lbp_addr + AW'(W-1)
                                                          : lbp_addr + AW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         row       <= LOG_H'(1);
         col       <= LOG_W'(1);
         idx       <= '0;
         win       <= '0;
         gray_req  <= 1'b0;
         gray_addr <= '0;
         lbp_valid <= 1'b0;
         lbp_addr  <= '0;
         lbp_data  <= '0;
         finish    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gray_ready) begin
               state     <= FETCH9;
               idx       <= '0;
               gray_req  <= 1'b1;
               gray_addr <= {row - LOG_H'(1), col - LOG_W'(1)};
            end
            FETCH9: begin
               if (idx != 4'd0) win[idx - 4'd1] <= gray_data;
               if (idx == 4'd8) begin
                  state    <= LAST;
                  gray_req <= 1'b0;
               end else begin
                  idx       <= nj;
                  gray_addr <= {f9_row, f9_col};
               end
            end
            FETCH3: begin
               case (idx)
                  4'd0: begin
                     win[0] <= win[1]; win[1] <= win[2];
                     win[3] <= win[4]; win[4] <= win[5];
                     win[6] <= win[7]; win[7] <= win[8];
                  end
                  4'd1:    win[2] <= gray_data;
                  default: win[5] <= gray_data;
               endcase
               if (idx == 4'd2) begin
                  state    <= LAST;
                  gray_req <= 1'b0;
               end else begin
                  idx       <= nj;
                  gray_addr <= {f3_row, f3_col};
               end
            end
            LAST: begin
               win[8] <= gray_data;
               state  <= CMP;
            end
            CMP: begin
               lbp_valid <= 1'b1;
               lbp_addr  <= {row, col};
               lbp_data  <= code;
               state     <= WR;
            end
            WR: begin
               idx <= '0;
               if (col < LOG_W'(W-2)) begin
                  col       <= col + LOG_W'(1);
                  lbp_valid <= 1'b0;
                  gray_req  <= 1'b1;
                  gray_addr <= {row - LOG_H'(1), col + LOG_W'(2)};
                  state     <= FETCH3;
               end else if (row < LOG_H'(H-2)) begin
                  row       <= row + LOG_H'(1);
                  col       <= LOG_W'(1);
                  lbp_valid <= 1'b0;
                  gray_req  <= 1'b1;
                  gray_addr <= {row, LOG_W'(0)};
                  state     <= FETCH9;
               end else if (BORDER_ZERO) begin
                  lbp_addr <= '0;
                  lbp_data <= '0;
                  state    <= BORDER;
               end else begin
                  lbp_valid <= 1'b0;
                  finish    <= 1'b1;
                  state     <= DONE;
               end
            end
            BORDER: begin
               if (lbp_addr == '1) begin
                  lbp_valid <= 1'b0;
                  finish    <= 1'b1;
                  state     <= DONE;
               end else begin
                  lbp_addr <= b_next;
               end
            end
            DONE: finish <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lbp_stream_engine.sv
// Bench for lbp_stream_engine on a 16x8, 10-bit image with border fill; every write is
// compared against a pixel-level reference built from the image and threshold.
module tb_lbp_stream_engine;
   localparam int LW = 4, LH = 3, DW = 10;
   localparam int W = 16, H = 8, N = 128, AW = 7;
   localparam int RUN_CYC = 6 * (12 + 6 * (W - 3)) + (2 * W + 2 * H - 4);
   localparam int REQS    = 6 * (9 + 3 * 13);

   logic          clk = 1'b0, reset = 1'b1, gray_ready = 1'b0;
   logic [DW-1:0] gray_data = '0, thr = '0;
   logic          gray_req, lbp_valid, finish;
   logic [AW-1:0] gray_addr, lbp_addr;
   logic [7:0]    lbp_data;

   lbp_stream_engine #(.LOG_W(LW), .LOG_H(LH), .DW(DW), .BORDER_ZERO(1'b1)) dut (
      .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_data(gray_data), .thr(thr),
      .gray_req(gray_req), .gray_addr(gray_addr), .lbp_valid(lbp_valid),
      .lbp_addr(lbp_addr), .lbp_data(lbp_data), .finish(finish));

   always #5 clk = ~clk;

   logic [DW-1:0] img [N];
   always @(posedge clk) if (gray_req) gray_data <= img[gray_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;
   int q_addr[$], q_data[$], e_addr[$], e_data[$];
   int req_cnt, first_req, fin_cyc, overlap;

   always @(negedge clk) begin
      if (!reset) begin
         if (lbp_valid) begin
            q_addr.push_back(int'(lbp_addr));
            q_data.push_back(int'(lbp_data));
         end
         if (gray_req) begin
            req_cnt++;
            if (first_req < 0) first_req = cyc;
         end
         if (finish && fin_cyc < 0) fin_cyc = cyc;
         if (gray_req && lbp_valid) overlap++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      q_addr.delete(); q_data.delete();
      req_cnt = 0; first_req = -1; fin_cyc = -1; overlap = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; gray_ready = 1'b0;
      repeat (2) @(negedge clk);
      clear_stats();
      reset = 1'b0;
   endtask

   task automatic fill(input int mode);
      for (int a = 0; a < N; a++) begin
         int r, c;
         r = a / W; c = a % W;
         case (mode)
            0:       img[a] = DW'('h40);
            1:       img[a] = DW'(c * 10);
            2:       img[a] = ((r + c) % 2 != 0) ? DW'('h3FF) : DW'('h3F0);
            default: img[a] = DW'($urandom_range(0, 1023));
         endcase
      end
   endtask

   // Reference: all interior codes in raster order, then zeros for every border pixel.
   task automatic build_exp(input int t);
      e_addr.delete(); e_data.delete();
      for (int r = 1; r <= H - 2; r++)
         for (int c = 1; c <= W - 2; c++) begin
            int cen, code, k;
            cen = int'(img[r * W + c]); code = 0; k = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (!(dr == 0 && dc == 0)) begin
                     if (int'(img[(r + dr) * W + c + dc]) >= cen + t) code |= (1 << k);
                     k++;
                  end
            e_addr.push_back(r * W + c); e_data.push_back(code);
         end
      for (int a = 0; a < N; a++)
         if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1) begin
            e_addr.push_back(a); e_data.push_back(0);
         end
   endtask

   task automatic start();
      @(negedge clk) gray_ready = 1'b1;
      @(negedge clk) gray_ready = 1'b0;
   endtask

   task automatic finish_and_check(input string tag);
      int n;
      for (int i = 0; i < 3000 && !finish; i++) @(negedge clk);
      chk({tag, " finish"}, 32'(finish), 32'd1);
      repeat (4) @(negedge clk);
      chk({tag, " sticky"}, 32'(finish), 32'd1);
      chk({tag, " nwr"}, 32'(q_addr.size()), 32'(e_addr.size()));
      n = (q_addr.size() < e_addr.size()) ? q_addr.size() : e_addr.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s wr%0d", tag, i), 32'((q_addr[i] << 16) | q_data[i]),
             32'((e_addr[i] << 16) | e_data[i]));
      chk({tag, " reqs"}, 32'(req_cnt), 32'(REQS));
      chk({tag, " latency"}, 32'(fin_cyc - first_req), 32'(RUN_CYC));
      chk({tag, " overlap"}, 32'(overlap), 32'd0);
   endtask

   task automatic run(input string tag, input int mode, input int t);
      do_reset();
      fill(mode);
      thr = DW'(t);
      build_exp(t);
      start();
      finish_and_check(tag);
   endtask

   initial begin
      @(negedge clk);
      chk("reset outs", 32'({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}), 32'd0);
      run("const thr0", 0, 0);
      run("const thr1", 0, 1);
      run("ramp", 1, 0);
      run("overflow", 2, 'h20);
      run("rand thr0", 3, 0);
      run("rand thrR", 3, $urandom_range(1, 63));

      // Abort partway through row 3, then rerun from scratch.
      do_reset();
      fill(3);
      thr = DW'($urandom_range(0, 15));
      build_exp(int'(thr));
      start();
      for (int i = 0; i < 3000 && !(lbp_valid && lbp_addr == AW'(3 * W + 5)); i++) @(negedge clk);
      chk("abort reached", 32'(lbp_valid && lbp_addr == AW'(3 * W + 5)), 32'd1);
      chk("abort no finish", 32'(finish), 32'd0);
      #2 reset = 1'b1;
      #1 chk("abort outs", 32'({gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}), 32'd0);
      @(negedge clk);
      clear_stats();
      reset = 1'b0;
      start();
      finish_and_check("restart");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
